// File: rtl/sample_capture.sv
// Purpose : logic-analyser capture engine; circular sample RAM writer with trigger and post-trigger count.
// Latency : probes->RAM write 3 clocks (2 sync + 1 reg); capture-end tick -> finished pulse 2 clocks.
// Backpress: none; sample_divider paces writes, abort cancels, arm while busy is ignored.
//
// Ports:
//   clock, reset_n          single clock, asynchronous active-low reset
//   probes                  asynchronous probe inputs (2-flop synchronised)
//   arm / abort             start capture (IDLE only) / cancel capture from any state
//   force_trigger           treat the next WAIT_TRIGGER sample as a match
//   sample_divider          sample every (sample_divider+1) clocks, latched at arm
//   trigger_mask/value      masked level compare, latched at arm
//   post_count_x4           post-trigger samples / 4, latched at arm
//   write_enable/address/data  RAM write port (one-cycle strobe)
//   last_sample_address     final write address of a completed capture
//   trigger_address         address of the trigger sample
//   busy / finished         capture in progress / one-cycle completion pulse
module sample_capture #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] probes,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  force_trigger,
    input  logic [15:0]           sample_divider,
    input  logic [DATA_WIDTH-1:0] trigger_mask,
    input  logic [DATA_WIDTH-1:0] trigger_value,
    input  logic [10:0]           post_count_x4,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [ADDR_WIDTH-1:0] last_sample_address,
    output logic [ADDR_WIDTH-1:0] trigger_address,
    output logic                  busy,
    output logic                  finished
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_TRIGGER = 2'd1,
        POST_TRIGGER = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sync1;
    logic [DATA_WIDTH-1:0] psync;
    logic [ADDR_WIDTH-1:0] pointer;
    logic [15:0]           div_cnt;
    logic [15:0]           div_l;
    logic [DATA_WIDTH-1:0] mask_l;
    logic [DATA_WIDTH-1:0] value_l;
    logic [10:0]           post_l;
    logic [ADDR_WIDTH-1:0] remaining;
    // Set on the final sample tick; the following cycle lets that write
    // complete before finished is raised and the FSM returns to IDLE.
    logic                  ending;

    logic tick;
    logic match;

    assign tick  = (state != IDLE) && !ending && (div_cnt == 16'd0);
    assign match = (((psync ^ value_l) & mask_l) == '0) || force_trigger;
    assign busy  = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            sync1               <= '0;
            psync               <= '0;
            pointer             <= '0;
            div_cnt             <= '0;
            div_l               <= '0;
            mask_l              <= '0;
            value_l             <= '0;
            post_l              <= '0;
            remaining           <= '0;
            ending              <= 1'b0;
            write_enable        <= 1'b0;
            write_address       <= '0;
            write_data          <= '0;
            last_sample_address <= '0;
            trigger_address     <= '0;
            finished            <= 1'b0;
        end else begin
            sync1        <= probes;
            psync        <= sync1;
            write_enable <= 1'b0;
            finished     <= 1'b0;

            if (abort) begin
                // A write strobe already registered still completes this cycle.
                state  <= IDLE;
                ending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            state   <= WAIT_TRIGGER;
                            pointer <= '0;
                            div_cnt <= '0;
                            div_l   <= sample_divider;
                            mask_l  <= trigger_mask;
                            value_l <= trigger_value;
                            post_l  <= post_count_x4;
                            ending  <= 1'b0;
                        end
                    end
                    default: begin
                        if (ending) begin
                            state               <= IDLE;
                            ending              <= 1'b0;
                            finished            <= 1'b1;
                            last_sample_address <= write_address;
                        end else begin
                            div_cnt <= (div_cnt == div_l) ? 16'd0 : div_cnt + 16'd1;
                            if (tick) begin
                                write_enable  <= 1'b1;
                                write_address <= pointer;
                                write_data    <= psync;
                                pointer       <= pointer + 1'b1;
                                if (state == WAIT_TRIGGER) begin
                                    if (match) begin
                                        trigger_address <= pointer;
                                        remaining       <= ADDR_WIDTH'({post_l, 2'b00});
                                        if (post_l == 11'd0) begin
                                            ending <= 1'b1;
                                        end else begin
                                            state <= POST_TRIGGER;
                                        end
                                    end
                                end else begin
                                    remaining <= remaining - 1'b1;
                                    if (remaining == ADDR_WIDTH'(1)) begin
                                        ending <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_capture.sv
module tb_sample_capture;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  probes;
    logic        arm;
    logic        abort;
    logic        force_trigger;
    logic [15:0] sample_divider;
    logic [7:0]  trigger_mask;
    logic [7:0]  trigger_value;
    logic [10:0] post_count_x4;
    logic        write_enable;
    logic [12:0] write_address;
    logic [7:0]  write_data;
    logic [12:0] last_sample_address;
    logic [12:0] trigger_address;
    logic        busy;
    logic        finished;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sample_capture #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .probes              (probes),
        .arm                 (arm),
        .abort               (abort),
        .force_trigger       (force_trigger),
        .sample_divider      (sample_divider),
        .trigger_mask        (trigger_mask),
        .trigger_value       (trigger_value),
        .post_count_x4       (post_count_x4),
        .write_enable        (write_enable),
        .write_address       (write_address),
        .write_data          (write_data),
        .last_sample_address (last_sample_address),
        .trigger_address     (trigger_address),
        .busy                (busy),
        .finished            (finished)
    );

    // Config + arm pulse; returns at the negedge right after arm was accepted,
    // so the next negedge observes the first sample tick (k=1).
    task automatic arm_capture(input logic [15:0] div, input logic [7:0] mask,
                               input logic [7:0] value, input logic [10:0] post);
        @(negedge clock);
        sample_divider = div;
        trigger_mask   = mask;
        trigger_value  = value;
        post_count_x4  = post;
        arm            = 1'b1;
        @(negedge clock);
        arm = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if ({write_enable, write_address, write_data, last_sample_address,
             trigger_address, busy, finished} !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b wa=%0d wd=%h last=%0d trig=%0d busy=%b fin=%b exp all 0",
                     write_enable, write_address, write_data, last_sample_address,
                     trigger_address, busy, finished);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [2:0] exp_ctl;
        probes = 8'h5A;
        repeat (3) @(negedge clock);
        arm_capture(16'd0, 8'h00, 8'h00, 11'd1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            exp_ctl = {k <= 5, k == 6, k <= 5};
            checks++;
            if ({write_enable, finished, busy} !== exp_ctl) begin
                errors++;
                $display("FAIL basic_ctl k=%0d got we/fin/busy=%b exp %b", k,
                         {write_enable, finished, busy}, exp_ctl);
            end
            if (k <= 5) begin
                checks++;
                if ({write_address, write_data} !== {13'(k - 1), 8'h5A}) begin
                    errors++;
                    $display("FAIL basic_write k=%0d got addr=%0d data=%h exp addr=%0d data=5a",
                             k, write_address, write_data, k - 1);
                end
            end
        end
        checks++;
        if (trigger_address !== 13'd0 || last_sample_address !== 13'd4) begin
            errors++;
            $display("FAIL basic_addrs got trig=%0d last=%0d exp trig=0 last=4",
                     trigger_address, last_sample_address);
        end
    endtask

    task automatic test_divider_trigger();
        logic [2:0] exp_ctl;
        logic       exp_we;
        int         j;
        probes = 8'h01;
        repeat (3) @(negedge clock);
        arm_capture(16'd3, 8'h80, 8'h80, 11'd1);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            exp_we  = ((k - 1) % 4 == 0) && (k <= 57);
            exp_ctl = {exp_we, k == 58, k <= 57};
            checks++;
            if ({write_enable, finished, busy} !== exp_ctl) begin
                errors++;
                $display("FAIL div_ctl k=%0d got we/fin/busy=%b exp %b", k,
                         {write_enable, finished, busy}, exp_ctl);
            end
            if (exp_we) begin
                j = (k - 1) / 4;
                checks++;
                if ({write_address, write_data} !== {13'(j), (j >= 10) ? 8'h81 : 8'h01}) begin
                    errors++;
                    $display("FAIL div_write k=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                             k, write_address, write_data, j, (j >= 10) ? 8'h81 : 8'h01);
                end
            end
            // Sample 9 sees probes from before this point, sample 10 from after.
            if (k == 36) probes = 8'h81;
        end
        checks++;
        if (trigger_address !== 13'd10 || last_sample_address !== 13'd14) begin
            errors++;
            $display("FAIL div_addrs got trig=%0d last=%0d exp trig=10 last=14",
                     trigger_address, last_sample_address);
        end
    endtask

    task automatic test_wrap();
        int writes   = 0;
        int pulses   = 0;
        int pulse_k  = 0;
        probes = 8'hFF;
        repeat (3) @(negedge clock);
        arm_capture(16'd0, 8'hFF, 8'h00, 11'd2);
        for (int k = 1; k <= 8212; k++) begin
            @(negedge clock);
            if (write_enable) writes++;
            if (finished) begin
                pulses++;
                pulse_k = k;
            end
            if (k == 8192 || k == 8193 || k == 8201 || k == 8209) begin
                checks++;
                if ({write_enable, write_address} !== {1'b1, 13'(k - 1)}) begin
                    errors++;
                    $display("FAIL wrap_addr k=%0d got we=%b addr=%0d exp we=1 addr=%0d",
                             k, write_enable, write_address, 13'(k - 1));
                end
            end
            if (k == 8200) force_trigger = 1'b1;
            if (k == 8201) force_trigger = 1'b0;
        end
        checks++;
        if (writes != 8209) begin
            errors++;
            $display("FAIL wrap_writes got %0d exp 8209", writes);
        end
        checks++;
        if (pulses != 1 || pulse_k != 8210) begin
            errors++;
            $display("FAIL wrap_finished got pulses=%0d at k=%0d exp 1 at k=8210", pulses, pulse_k);
        end
        checks++;
        if (trigger_address !== 13'd8 || last_sample_address !== 13'd16) begin
            errors++;
            $display("FAIL wrap_addrs got trig=%0d last=%0d exp trig=8 last=16",
                     trigger_address, last_sample_address);
        end
    endtask

    task automatic test_post_zero();
        logic [2:0] exp_ctl;
        probes = 8'h3C;
        repeat (3) @(negedge clock);
        arm_capture(16'd0, 8'h00, 8'h00, 11'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            exp_ctl = {k == 1, k == 2, k == 1};
            checks++;
            if ({write_enable, finished, busy} !== exp_ctl) begin
                errors++;
                $display("FAIL post0_ctl k=%0d got we/fin/busy=%b exp %b", k,
                         {write_enable, finished, busy}, exp_ctl);
            end
            if (k == 1) begin
                checks++;
                if ({write_address, write_data} !== {13'd0, 8'h3C}) begin
                    errors++;
                    $display("FAIL post0_write got addr=%0d data=%h exp addr=0 data=3c",
                             write_address, write_data);
                end
            end
        end
        checks++;
        if (trigger_address !== 13'd0 || last_sample_address !== 13'd0) begin
            errors++;
            $display("FAIL post0_addrs got trig=%0d last=%0d exp 0/0",
                     trigger_address, last_sample_address);
        end
    endtask

    task automatic test_abort();
        int pulses = 0;
        arm_capture(16'd0, 8'h00, 8'h00, 11'd2);
        for (int k = 1; k <= 3; k++) @(negedge clock);
        checks++;
        if ({write_enable, write_address, busy} !== {1'b1, 13'd2, 1'b1}) begin
            errors++;
            $display("FAIL abort_pre got we=%b addr=%0d busy=%b exp 1/2/1",
                     write_enable, write_address, busy);
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checks++;
        if ({write_enable, busy, finished} !== 3'b000) begin
            errors++;
            $display("FAIL abort_stop got we/busy/fin=%b exp 000", {write_enable, busy, finished});
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (finished) pulses++;
        end
        checks++;
        if (pulses != 0 || last_sample_address !== 13'd0) begin
            errors++;
            $display("FAIL abort_nofinish got pulses=%0d last=%0d exp 0/0", pulses, last_sample_address);
        end
        // arm and abort together in IDLE: stay idle
        arm   = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        arm   = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL arm_abort_idle got busy=%b exp 0", busy);
        end
        arm_capture(16'd0, 8'h00, 8'h00, 11'd2);
        @(negedge clock);
        checks++;
        if ({write_enable, write_address, busy} !== {1'b1, 13'd0, 1'b1}) begin
            errors++;
            $display("FAIL abort_rearm got we=%b addr=%0d busy=%b exp 1/0/1",
                     write_enable, write_address, busy);
        end
        repeat (12) @(negedge clock);
    endtask

    task automatic test_reset_mid_capture();
        probes = 8'hFF;
        repeat (3) @(negedge clock);
        arm_capture(16'd0, 8'hFF, 8'h00, 11'd1);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({write_enable, write_address, write_data, last_sample_address,
             trigger_address, busy, finished} !== 51'd0) begin
            errors++;
            $display("FAIL midreset_outputs got we=%b wa=%0d wd=%h last=%0d trig=%0d busy=%b fin=%b exp all 0",
                     write_enable, write_address, write_data, last_sample_address,
                     trigger_address, busy, finished);
        end
        @(negedge clock);
        reset_n = 1'b1;
        arm_capture(16'd0, 8'hFF, 8'h00, 11'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            checks++;
            if ({write_enable, write_address, busy} !== {1'b1, 13'(k - 1), 1'b1}) begin
                errors++;
                $display("FAIL rearm_busy k=%0d got we=%b addr=%0d busy=%b exp 1/%0d/1",
                         k, write_enable, write_address, busy, k - 1);
            end
            arm = (k == 3);
        end
        arm   = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL final_abort got busy=%b exp 0", busy);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        probes         = 8'h00;
        arm            = 1'b0;
        abort          = 1'b0;
        force_trigger  = 1'b0;
        sample_divider = 16'd0;
        trigger_mask   = 8'h00;
        trigger_value  = 8'h00;
        post_count_x4  = 11'd0;

        test_reset();
        test_basic();
        test_divider_trigger();
        test_wrap();
        test_post_zero();
        test_abort();
        test_reset_mid_capture();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
